// File: rtl/ifu_axi_fetch.sv
// Instruction-fetch AXI4 read master: issues single-beat reads for the PC,
// tracks in-flight requests, drops stale beats after a flush, buffers results in order.
module ifu_axi_fetch #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 2,
   parameter int FIFO_DEPTH      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              fetch_en_i,
   input  logic              flush_i,
   output logic              pc_adv_o,
   output logic [ADDR_W-1:0] araddr_o,
   output logic              arvalid_o,
   input  logic              arready_i,
   output logic [3:0]        arid_o,
   output logic [7:0]        arlen_o,
   output logic [2:0]        arsize_o,
   output logic [1:0]        arburst_o,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [1:0]        rresp_i,
   input  logic              rvalid_i,
   output logic              rready_o,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   output logic              inst_err_o,
   output logic              inst_valid_o,
   input  logic              inst_ready_i
);

   localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int FCW = $clog2(FIFO_DEPTH + 1);
   localparam int QPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic              ar_vld_q, ar_stale_q, rready_q;
   logic [ADDR_W-1:0] ar_addr_q;
   logic [CW-1:0]     out_cnt_q, live_cnt_q, drop_cnt_q;
   logic [CW-1:0]     out_cnt_d, live_cnt_d, drop_cnt_d;
   logic [ADDR_W-1:0] aq_mem_q [MAX_OUTSTANDING];
   logic [QPW-1:0]    aq_wp_q, aq_rp_q;
   logic [DATA_W-1:0] fd_mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] fa_mem_q [FIFO_DEPTH];
   logic              fe_mem_q [FIFO_DEPTH];
   logic [FPW-1:0]    f_wp_q, f_rp_q;
   logic [FCW-1:0]    fifo_cnt_q, fifo_cnt_d;

   logic ar_hs, r_beat, credit, load, fifo_empty, consume;
   logic beat_keep, beat_drop, aq_push;

   function automatic logic [QPW-1:0] aq_inc(input logic [QPW-1:0] p);
      return (p == QPW'(MAX_OUTSTANDING - 1)) ? '0 : p + QPW'(1);
   endfunction

   function automatic logic [FPW-1:0] f_inc(input logic [FPW-1:0] p);
      return (p == FPW'(FIFO_DEPTH - 1)) ? '0 : p + FPW'(1);
   endfunction

   // Credit reserves FIFO space for every live request, so rready can stay high.
   always_comb begin
      ar_hs      = ar_vld_q && arready_i;
      r_beat     = rvalid_i && rready_q;
      credit     = (32'(live_cnt_q) + 32'(fifo_cnt_q) + 32'(ar_vld_q) < 32'(FIFO_DEPTH)) &&
                   (32'(out_cnt_q) + 32'(ar_vld_q) < 32'(MAX_OUTSTANDING));
      load       = !rst && !ar_vld_q && fetch_en_i && !flush_i && credit;
      fifo_empty = (fifo_cnt_q == '0);
      beat_drop  = r_beat && (flush_i || drop_cnt_q != '0);
      beat_keep  = r_beat && !beat_drop;
      aq_push    = ar_hs && !ar_stale_q && !flush_i;
      consume    = !fifo_empty && !flush_i && inst_ready_i;
      out_cnt_d  = out_cnt_q + CW'(ar_hs) - CW'(r_beat);
      if (flush_i) begin
         // Everything live plus a request handshaking right now becomes stale.
         drop_cnt_d = drop_cnt_q + live_cnt_q + CW'(ar_hs) - CW'(r_beat);
         live_cnt_d = '0;
         fifo_cnt_d = '0;
      end else begin
         drop_cnt_d = drop_cnt_q + CW'(ar_hs && ar_stale_q) - CW'(beat_drop);
         live_cnt_d = live_cnt_q + CW'(aq_push) - CW'(beat_keep);
         fifo_cnt_d = fifo_cnt_q + FCW'(beat_keep) - FCW'(consume);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ar_vld_q   <= 1'b0;
         ar_stale_q <= 1'b0;
         ar_addr_q  <= '0;
         rready_q   <= 1'b0;
         out_cnt_q  <= '0;
         live_cnt_q <= '0;
         drop_cnt_q <= '0;
         fifo_cnt_q <= '0;
         aq_wp_q    <= '0;
         aq_rp_q    <= '0;
         f_wp_q     <= '0;
         f_rp_q     <= '0;
      end else begin
         rready_q   <= 1'b1;
         out_cnt_q  <= out_cnt_d;
         live_cnt_q <= live_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         fifo_cnt_q <= fifo_cnt_d;
         if (load) begin
            ar_vld_q   <= 1'b1;
            ar_addr_q  <= pc_i;
            ar_stale_q <= 1'b0;
         end else begin
            if (ar_hs)   ar_vld_q   <= 1'b0;
            if (flush_i) ar_stale_q <= ar_vld_q;
         end
         if (flush_i) begin
            aq_wp_q <= '0;
            aq_rp_q <= '0;
            f_wp_q  <= '0;
            f_rp_q  <= '0;
         end else begin
            if (aq_push)   aq_wp_q <= aq_inc(aq_wp_q);
            if (beat_keep) aq_rp_q <= aq_inc(aq_rp_q);
            if (beat_keep) f_wp_q  <= f_inc(f_wp_q);
            if (consume)   f_rp_q  <= f_inc(f_rp_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (aq_push) aq_mem_q[aq_wp_q] <= ar_addr_q;
      if (beat_keep) begin
         fd_mem_q[f_wp_q] <= rdata_i;
         fa_mem_q[f_wp_q] <= aq_mem_q[aq_rp_q];
         fe_mem_q[f_wp_q] <= (rresp_i != 2'b00);
      end
   end

   assign pc_adv_o     = load;
   assign araddr_o     = ar_addr_q;
   assign arvalid_o    = ar_vld_q;
   assign arid_o       = 4'd0;
   assign arlen_o      = 8'd0;
   assign arsize_o     = 3'b010;
   assign arburst_o    = 2'b01;
   assign rready_o     = rready_q;
   assign inst_valid_o = !fifo_empty && !flush_i;
   assign inst_o       = fifo_empty ? '0 : fd_mem_q[f_rp_q];
   assign inst_addr_o  = fifo_empty ? '0 : fa_mem_q[f_rp_q];
   assign inst_err_o   = fifo_empty ? 1'b0 : fe_mem_q[f_rp_q];

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Directed bench for ifu_axi_fetch: PC register model, delayed AXI read slave,
// and an in-order scoreboard of expected deliveries.
module tb_ifu_axi_fetch;

   localparam int MAXO = 2;
   localparam int FDEP = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        fetch_en_i, flush_i, pc_adv_o;
   logic [31:0] araddr_o;
   logic        arvalid_o, arready_i;
   logic [3:0]  arid_o;
   logic [7:0]  arlen_o;
   logic [2:0]  arsize_o;
   logic [1:0]  arburst_o;
   logic [31:0] rdata_i;
   logic [1:0]  rresp_i;
   logic        rvalid_i, rready_o;
   logic [31:0] inst_o, inst_addr_o;
   logic        inst_err_o, inst_valid_o, inst_ready_i;

   ifu_axi_fetch #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAXO), .FIFO_DEPTH(FDEP)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .fetch_en_i(fetch_en_i), .flush_i(flush_i),
      .pc_adv_o(pc_adv_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
      .arid_o(arid_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
      .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_err_o(inst_err_o),
      .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // PC register: advances on pc_adv_o, jumps on flush
   logic [31:0] jump_tgt, pc_q;
   assign pc_i = pc_q;
   always @(posedge clk) begin
      if (rst)            pc_q <= 32'h8000_0000;
      else if (flush_i)   pc_q <= jump_tgt;
      else if (pc_adv_o)  pc_q <= pc_q + 32'd4;
   end

   // AXI read slave: beat two cycles after the AR handshake, data = ~addr
   typedef struct { logic [31:0] addr; int due; } req_t;
   req_t        sq[$];
   req_t        sr;
   int          cyc = 0;
   logic        slv_en;
   logic [31:0] err_addr;
   always @(posedge clk) begin
      if (rst) begin
         sq.delete();
         rvalid_i <= 1'b0;
         rdata_i  <= '0;
         rresp_i  <= 2'b00;
      end else begin
         if (arvalid_o && arready_i) sq.push_back('{araddr_o, cyc + 2});
         if (slv_en && sq.size() > 0 && sq[0].due <= cyc + 1) begin
            sr = sq.pop_front();
            rvalid_i <= 1'b1;
            rdata_i  <= ~sr.addr;
            rresp_i  <= (sr.addr == err_addr) ? 2'b10 : 2'b00;
         end else begin
            rvalid_i <= 1'b0;
            rdata_i  <= '0;
            rresp_i  <= 2'b00;
         end
      end
      cyc++;
   end

   // Scoreboard: expected entry pushed when a PC is captured, popped on delivery
   typedef struct { logic [31:0] addr; logic [31:0] data; logic err; } exp_t;
   exp_t sb[$];
   exp_t se;
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (inst_valid_o && inst_ready_i) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               se = sb.pop_front();
               chk("inst_addr", inst_addr_o, se.addr);
               chk("inst_data", inst_o, se.data);
               chk("inst_err", 32'(inst_err_o), 32'(se.err));
            end
         end
         if (flush_i)       sb.delete();
         else if (pc_adv_o) sb.push_back('{pc_i, ~pc_i, pc_i == err_addr});
         chk("out_bound", 32'(32'(dut.out_cnt_q) <= 32'(MAXO)), 32'd1);
         chk("fifo_bound", 32'(32'(dut.fifo_cnt_q) <= 32'(FDEP)), 32'd1);
      end
   end

   logic [31:0] a0;

   initial begin
      rst = 1'b1; fetch_en_i = 1'b0; flush_i = 1'b0; arready_i = 1'b1;
      inst_ready_i = 1'b1; slv_en = 1'b1; jump_tgt = '0; err_addr = 32'h8000_0208;
      tick(); tick();
      fetch_en_i = 1'b1;
      #1;
      chk("rst_arvalid", 32'(arvalid_o), 32'd0);
      chk("rst_araddr", araddr_o, 32'd0);
      chk("rst_pc_adv", 32'(pc_adv_o), 32'd0);
      chk("rst_rready", 32'(rready_o), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
      chk("rst_inst", inst_o, 32'd0);
      chk("rst_inst_addr", inst_addr_o, 32'd0);
      chk("rst_inst_err", 32'(inst_err_o), 32'd0);
      chk("ar_const", {arid_o, arlen_o, arsize_o, arburst_o}, {4'd0, 8'd0, 3'b010, 2'b01, 15'd0} >> 15);

      // basic fetch
      rst = 1'b0;
      #1;
      chk("basic_pc_adv0", 32'(pc_adv_o), 32'd1);
      tick();
      chk("basic_arvalid0", 32'(arvalid_o), 32'd1);
      chk("basic_araddr0", araddr_o, 32'h8000_0000);
      chk("basic_no_adv", 32'(pc_adv_o), 32'd0);
      chk("basic_rready", 32'(rready_o), 32'd1);
      tick();
      chk("basic_ar_idle", 32'(arvalid_o), 32'd0);
      chk("basic_pc_adv1", 32'(pc_adv_o), 32'd1);
      tick();
      chk("basic_araddr1", araddr_o, 32'h8000_0004);
      tick();
      chk("basic_valid", 32'(inst_valid_o), 32'd1);
      chk("basic_inst_addr", inst_addr_o, 32'h8000_0000);
      chk("basic_inst", inst_o, 32'h7FFF_FFFF);

      // backpressure
      inst_ready_i = 1'b0;
      repeat (12) tick();
      chk("bp_fifo_full", 32'(dut.fifo_cnt_q), 32'd2);
      for (int i = 0; i < 3; i++) begin
         chk("bp_no_adv", 32'(pc_adv_o), 32'd0);
         chk("bp_no_ar", 32'(arvalid_o), 32'd0);
         chk("bp_valid", 32'(inst_valid_o), 32'd1);
         tick();
      end
      inst_ready_i = 1'b1;
      #1;
      chk("bp_pop_cycle_adv", 32'(pc_adv_o), 32'd0);
      tick();
      chk("bp_resume_adv", 32'(pc_adv_o), 32'd1);

      // flush masks a full FIFO and empties it
      inst_ready_i = 1'b0;
      repeat (12) tick();
      chk("fm_valid_before", 32'(inst_valid_o), 32'd1);
      flush_i = 1'b1; jump_tgt = 32'h8000_0300;
      #1;
      chk("fm_masked", 32'(inst_valid_o), 32'd0);
      chk("fm_no_load", 32'(pc_adv_o), 32'd0);
      tick();
      flush_i = 1'b0;
      #1;
      chk("fm_empty", 32'(inst_valid_o), 32'd0);
      chk("fm_load_next", 32'(pc_adv_o), 32'd1);
      tick();
      chk("fm_araddr", araddr_o, 32'h8000_0300);
      inst_ready_i = 1'b1;

      // flush with two outstanding, old beats return afterwards
      slv_en = 1'b0;
      repeat (12) tick();
      chk("f2_outstanding", 32'(dut.out_cnt_q), 32'd2);
      flush_i = 1'b1; jump_tgt = 32'h8000_0100;
      tick();
      flush_i = 1'b0; slv_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("f2_dropped", 32'(inst_valid_o), 32'd0);
         tick();
      end
      for (int i = 0; i < 30 && !inst_valid_o; i++) tick();
      chk("f2_first_addr", inst_addr_o, 32'h8000_0100);

      // flush while AR is stalled
      arready_i = 1'b0;
      for (int i = 0; i < 20 && !arvalid_o; i++) tick();
      chk("fa_arvalid", 32'(arvalid_o), 32'd1);
      a0 = araddr_o;
      flush_i = 1'b1; jump_tgt = 32'h8000_0200;
      tick();
      flush_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("fa_addr_held", araddr_o, a0);
         chk("fa_arvalid_held", 32'(arvalid_o), 32'd1);
         tick();
      end
      arready_i = 1'b1;
      for (int i = 0; i < 30 && !inst_valid_o; i++) tick();
      chk("fa_first_addr", inst_addr_o, 32'h8000_0200);

      // error response on one entry only
      for (int i = 0; i < 40 && !(inst_valid_o && inst_addr_o == err_addr); i++) tick();
      chk("err_addr", inst_addr_o, err_addr);
      chk("err_flag", 32'(inst_err_o), 32'd1);
      tick();
      for (int i = 0; i < 20 && !inst_valid_o; i++) tick();
      chk("err_next_addr", inst_addr_o, err_addr + 32'd4);
      chk("err_next_flag", 32'(inst_err_o), 32'd0);

      // synchronous reset mid-burst
      for (int i = 0; i < 20 && !arvalid_o; i++) tick();
      rst = 1'b1;
      tick();
      chk("mrst_arvalid", 32'(arvalid_o), 32'd0);
      chk("mrst_araddr", araddr_o, 32'd0);
      chk("mrst_pc_adv", 32'(pc_adv_o), 32'd0);
      chk("mrst_rready", 32'(rready_o), 32'd0);
      chk("mrst_valid", 32'(inst_valid_o), 32'd0);
      chk("mrst_inst", inst_o, 32'd0);
      chk("mrst_counters", 32'({dut.out_cnt_q, dut.live_cnt_q, dut.drop_cnt_q}), 32'd0);
      rst = 1'b0;
      #1;
      chk("mrst_restart_adv", 32'(pc_adv_o), 32'd1);
      tick();
      chk("mrst_araddr0", araddr_o, 32'h8000_0000);
      for (int i = 0; i < 20 && !inst_valid_o; i++) tick();
      chk("mrst_first_addr", inst_addr_o, 32'h8000_0000);

      // drain
      fetch_en_i = 1'b0;
      repeat (15) tick();
      chk("drain_sb", 32'(sb.size()), 32'd0);
      chk("drain_valid", 32'(inst_valid_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
